// File: rtl/knn_pkg.sv
// Shared widths, FSM encoding and the empty-slot sentinel for the KNN top-K sorter.
package knn_pkg;

    localparam int K_DEF       = 10;
    localparam int DIST_W_DEF  = 24;
    localparam int LABEL_W_DEF = 8;

    localparam logic [DIST_W_DEF-1:0] DIST_MAX = {DIST_W_DEF{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_t;

endpackage

// File: rtl/knn_topk_cell.sv
// One slot of the sorted top-K array: decides whether a candidate belongs here or earlier,
// then takes the candidate, shifts in the previous slot, or holds.
module knn_topk_cell #(
    parameter int DIST_W  = 24,
    parameter int LABEL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic [DIST_W-1:0]  dist_in,
    input  logic [LABEL_W-1:0] label_in,
    input  logic               ins_prev,
    input  logic               prev_valid,
    input  logic [DIST_W-1:0]  prev_dist,
    input  logic [LABEL_W-1:0] prev_label,
    output logic               ins_o,
    output logic               valid_o,
    output logic [DIST_W-1:0]  dist_o,
    output logic [LABEL_W-1:0] label_o
);

    logic               valid_q, valid_d;
    logic [DIST_W-1:0]  dist_q,  dist_d;
    logic [LABEL_W-1:0] label_q, label_d;

    // Strict compare keeps equal distances in arrival order.
    assign ins_o = !valid_q || (dist_in < dist_q);

    always_comb begin
        valid_d = valid_q;
        dist_d  = dist_q;
        label_d = label_q;
        if (clr) begin
            valid_d = 1'b0;
            dist_d  = {DIST_W{1'b1}};
            label_d = '0;
        end else if (en) begin
            if (ins_prev) begin
                valid_d = prev_valid;
                dist_d  = prev_dist;
                label_d = prev_label;
            end else if (ins_o) begin
                valid_d = 1'b1;
                dist_d  = dist_in;
                label_d = label_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            dist_q  <= {DIST_W{1'b1}};
            label_q <= '0;
        end else begin
            valid_q <= valid_d;
            dist_q  <= dist_d;
            label_q <= label_d;
        end
    end

    assign valid_o = valid_q;
    assign dist_o  = dist_q;
    assign label_o = label_q;

endmodule

// File: rtl/knn_topk_sorter.sv
// Keeps the K nearest (distance, label) pairs of a query in ascending order, then drains
// exactly K words {label, dist} nearest first; empty slots go out as {0, all-ones}.
module knn_topk_sorter
    import knn_pkg::*;
#(
    parameter int K       = K_DEF,
    parameter int DIST_W  = DIST_W_DEF,
    parameter int LABEL_W = LABEL_W_DEF,
    parameter int DATA_W  = LABEL_W + DIST_W
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic               start,
    input  logic               dist_valid,
    input  logic [DIST_W-1:0]  dist_in,
    input  logic [LABEL_W-1:0] label_in,
    input  logic               last_in,
    output logic               in_ready,
    output logic [DATA_W-1:0]  AXIS_data,
    output logic               wr_en,
    output logic               done
);

    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [DATA_W-1:0]  data_q,  data_d;
    logic               wr_en_q, wr_en_d;
    logic               done_q,  done_d;
    logic               clr;
    logic               accept;

    logic               s_ins   [K];
    logic               s_valid [K];
    logic [DIST_W-1:0]  s_dist  [K];
    logic [LABEL_W-1:0] s_label [K];
    logic               p_ins   [K];
    logic               p_valid [K];
    logic [DIST_W-1:0]  p_dist  [K];
    logic [LABEL_W-1:0] p_label [K];
    logic [DATA_W-1:0]  s_word  [K];

    assign accept = (state_q == COLLECT) && dist_valid;

    for (genvar i = 0; i < K; i++) begin : g_slot
        if (i == 0) begin : g_head
            assign p_ins[i]   = 1'b0;
            assign p_valid[i] = 1'b0;
            assign p_dist[i]  = {DIST_W{1'b1}};
            assign p_label[i] = '0;
        end else begin : g_chain
            assign p_ins[i]   = s_ins[i-1];
            assign p_valid[i] = s_valid[i-1];
            assign p_dist[i]  = s_dist[i-1];
            assign p_label[i] = s_label[i-1];
        end

        knn_topk_cell #(
            .DIST_W  (DIST_W),
            .LABEL_W (LABEL_W)
        ) u_cell (
            .clk        (ACLK),
            .rst        (ARESET),
            .clr        (clr),
            .en         (accept),
            .dist_in    (dist_in),
            .label_in   (label_in),
            .ins_prev   (p_ins[i]),
            .prev_valid (p_valid[i]),
            .prev_dist  (p_dist[i]),
            .prev_label (p_label[i]),
            .ins_o      (s_ins[i]),
            .valid_o    (s_valid[i]),
            .dist_o     (s_dist[i]),
            .label_o    (s_label[i])
        );

        assign s_word[i] = s_valid[i] ? {s_label[i], s_dist[i]}
                                      : {{LABEL_W{1'b0}}, {DIST_W{1'b1}}};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        wr_en_d = 1'b0;
        clr     = 1'b0;
        // Only the final drained word is still on wr_en once the FSM is back in IDLE.
        done_d  = wr_en_q && (state_q == IDLE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    clr     = 1'b1;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                cnt_d = '0;
                if (accept && last_in) state_d = DRAIN;
            end
            DRAIN: begin
                wr_en_d = 1'b1;
                data_d  = s_word[cnt_q];
                if (cnt_q == CNT_W'(K - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            wr_en_q <= wr_en_d;
            done_q  <= done_d;
        end
    end

    assign in_ready  = (state_q == COLLECT);
    assign AXIS_data = data_q;
    assign wr_en     = wr_en_q;
    assign done      = done_q;

endmodule
